// File: rtl/avst_width_upconverter.sv
// Avalon-ST width upconverter: packs K = DATA_OUT_W/DATA_IN_W beats per word.
// Optional protocol check (src_error_o) enabled by AVST_UPCONV_PROTOCOL_CHECK_EN.
module avst_width_upconverter #(
    parameter int DATA_IN_W   = 64,
    parameter int DATA_OUT_W  = 128,
    parameter int CHANNEL_W   = 10,
    parameter int EMPTY_IN_W  = (DATA_IN_W / 8 > 1) ? $clog2(DATA_IN_W / 8) : 1,
    parameter int EMPTY_OUT_W = (DATA_OUT_W / 8 > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [DATA_IN_W-1:0]   snk_data_i,
    input  logic                   snk_startofpacket_i,
    input  logic                   snk_endofpacket_i,
    input  logic [EMPTY_IN_W-1:0]  snk_empty_i,
    input  logic [CHANNEL_W-1:0]   snk_channel_i,
    input  logic                   snk_valid_i,
    output logic                   snk_ready_o,
    output logic [DATA_OUT_W-1:0]  src_data_o,
    output logic                   src_startofpacket_o,
    output logic                   src_endofpacket_o,
    output logic [EMPTY_OUT_W-1:0] src_empty_o,
    output logic [CHANNEL_W-1:0]   src_channel_o,
    output logic                   src_valid_o,
    input  logic                   src_ready_i
`ifdef AVST_UPCONV_PROTOCOL_CHECK_EN
    ,
    output logic                   src_error_o
`endif
);

    localparam int K        = DATA_OUT_W / DATA_IN_W;
    localparam int CNT_W    = (K > 1) ? $clog2(K) : 1;
    localparam int BYTES_IN = DATA_IN_W / 8;

    typedef enum logic {COLLECT, HOLD} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_OUT_W-1:0]  data_q, data_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic [EMPTY_OUT_W-1:0] empty_q, empty_d;
    logic [CHANNEL_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]       lane;
    logic                   acc;
    logic                   last;
`ifdef AVST_UPCONV_PROTOCOL_CHECK_EN
    logic                   err_q, err_d;
    logic                   in_pkt_q, in_pkt_d;
    logic                   viol;
`endif

    // In HOLD an accepted beat always starts the next word at lane 0.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        empty_d     = empty_q;
        ch_d        = ch_q;
        lane        = (state_q == HOLD) ? '0 : cnt_q;
        snk_ready_o = (state_q == COLLECT) | src_ready_i;
        acc         = snk_valid_i & snk_ready_o;
        last        = (int'(lane) == K - 1) | snk_endofpacket_i;
`ifdef AVST_UPCONV_PROTOCOL_CHECK_EN
        err_d       = err_q;
        in_pkt_d    = in_pkt_q;
        viol        = in_pkt_q ? snk_startofpacket_i : ~snk_startofpacket_i;
        if (lane != '0 && snk_channel_i != ch_q) viol = 1'b1;
`endif
        if (acc) begin
            if (lane == '0) begin
                data_d  = '0;
                sop_d   = snk_startofpacket_i;
                ch_d    = snk_channel_i;
                eop_d   = 1'b0;
                empty_d = '0;
            end
            for (int k = 0; k < K; k++) begin
                if (lane == CNT_W'(k))
                    data_d[DATA_OUT_W-1-k*DATA_IN_W -: DATA_IN_W] = snk_data_i;
            end
            if (snk_endofpacket_i) begin
                eop_d   = 1'b1;
                empty_d = EMPTY_OUT_W'((K - 1 - int'(lane)) * BYTES_IN
                                       + int'(snk_empty_i));
            end
            if (last) begin
                state_d = HOLD;
                cnt_d   = '0;
            end else begin
                state_d = COLLECT;
                cnt_d   = lane + CNT_W'(1);
            end
`ifdef AVST_UPCONV_PROTOCOL_CHECK_EN
            err_d    = (lane == '0) ? viol : (err_q | viol);
            in_pkt_d = ~snk_endofpacket_i;
`endif
        end else if (state_q == HOLD && src_ready_i) begin
            state_d = COLLECT;
            cnt_d   = '0;
        end
    end

    // State and word registers; reset discards any partial word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            data_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            empty_q  <= '0;
            ch_q     <= '0;
`ifdef AVST_UPCONV_PROTOCOL_CHECK_EN
            err_q    <= 1'b0;
            in_pkt_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            empty_q  <= empty_d;
            ch_q     <= ch_d;
`ifdef AVST_UPCONV_PROTOCOL_CHECK_EN
            err_q    <= err_d;
            in_pkt_q <= in_pkt_d;
`endif
        end
    end

    assign src_data_o          = data_q;
    assign src_startofpacket_o = sop_q;
    assign src_endofpacket_o   = eop_q;
    assign src_empty_o         = empty_q;
    assign src_channel_o       = ch_q;
    assign src_valid_o         = (state_q == HOLD);
`ifdef AVST_UPCONV_PROTOCOL_CHECK_EN
    assign src_error_o         = err_q;
`endif

endmodule

// File: tb/tb_avst_width_upconverter.sv
// Randomised bench for avst_width_upconverter (64 -> 128, K=2)
// with a beat-list packing reference model.
module tb_avst_width_upconverter;
    localparam int IN  = 64;
    localparam int OUT = 128;
    localparam int K   = OUT / IN;

    logic clk = 1'b0;
    logic rst_n;
    logic [IN-1:0]  snk_data;
    logic           snk_sop, snk_eop, snk_valid, snk_ready;
    logic [2:0]     snk_empty;
    logic [9:0]     snk_ch;
    logic [OUT-1:0] src_data;
    logic           src_sop, src_eop, src_valid;
    logic           src_ready = 1'b1;
    logic [3:0]     src_empty;
    logic [9:0]     src_ch;
    logic           src_err;

    avst_width_upconverter #(.DATA_IN_W(IN), .DATA_OUT_W(OUT), .CHANNEL_W(10)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop),
        .snk_endofpacket_i(snk_eop), .snk_empty_i(snk_empty),
        .snk_channel_i(snk_ch), .snk_valid_i(snk_valid), .snk_ready_o(snk_ready),
        .src_data_o(src_data), .src_startofpacket_o(src_sop),
        .src_endofpacket_o(src_eop), .src_empty_o(src_empty),
        .src_channel_o(src_ch), .src_valid_o(src_valid), .src_ready_i(src_ready)
`ifdef AVST_UPCONV_PROTOCOL_CHECK_EN
        , .src_error_o(src_err)
`endif
    );
`ifndef AVST_UPCONV_PROTOCOL_CHECK_EN
    assign src_err = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [127:0] data;
        logic         sop, eop, err;
        logic [3:0]   empty;
        logic [9:0]   ch;
    } word_t;

    word_t        exp_q[$];
    word_t        log_q[$];
    int           hs_cyc[$];
    logic [63:0]  beats[$];
    logic [63:0]  sent[$];
    logic         m_sop, m_err, m_inpkt;
    logic [9:0]   m_ch;
    int           cyc = 0;
    int           rdy_mode = 0;

    // Reference: collect beats of the current word, pack first beat into MSBs.
    task automatic model_beat(input logic [63:0] d, input logic s, input logic e,
                              input logic [2:0] em, input logic [9:0] c);
        word_t w;
        logic v;
        if (beats.size() == 0) begin
            m_sop = s; m_ch = c; m_err = 1'b0;
        end
        v = (m_inpkt ? s : !s) || (beats.size() > 0 && c != m_ch);
        m_err   = m_err | v;
        m_inpkt = !e;
        beats.push_back(d);
        if (e || beats.size() == K) begin
            w.data = '0;
            for (int i = 0; i < beats.size(); i++)
                w.data = w.data | (128'(beats[i]) << (OUT - (i + 1) * IN));
            w.sop   = m_sop;
            w.eop   = e;
            w.ch    = m_ch;
            w.err   = m_err;
            w.empty = e ? 4'((K - beats.size()) * 8 + int'(em)) : 4'd0;
            exp_q.push_back(w);
            beats.delete();
        end
    endtask

    logic         pv, pr, p_sop, p_eop;
    logic [127:0] p_data;
    logic [3:0]   p_empty;
    logic [9:0]   p_ch;

    // Monitor: scoreboard, backpressure stability and ready rule.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pv = 1'b0;
            beats.delete();
            exp_q.delete();
            m_inpkt = 1'b0;
        end else begin
            chk("snk_ready", 128'(snk_ready), src_valid ? 128'(src_ready) : 128'd1);
            if (pv && !pr) begin
                chk("stall_valid", 128'(src_valid), 128'd1);
                chk("stall_data", src_data, p_data);
                chk("stall_ctl", {p_sop, src_sop, src_eop, src_empty, src_ch},
                     {src_sop, p_sop, p_eop, p_empty, p_ch});
            end
            if (src_valid && src_ready) begin
                word_t o;
                o.data = src_data; o.sop = src_sop; o.eop = src_eop;
                o.empty = src_empty; o.ch = src_ch; o.err = src_err;
                log_q.push_back(o);
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 128'd1, 128'd0);
                end else begin
                    word_t x;
                    x = exp_q.pop_front();
                    chk("sb_data", src_data, x.data);
                    chk("sb_ctl", {src_sop, src_eop, src_empty, src_ch},
                        {x.sop, x.eop, x.empty, x.ch});
`ifdef AVST_UPCONV_PROTOCOL_CHECK_EN
                    chk("sb_err", 128'(src_err), 128'(x.err));
`endif
                end
            end
            if (snk_valid && snk_ready)
                model_beat(snk_data, snk_sop, snk_eop, snk_empty, snk_ch);
            pv = src_valid; pr = src_ready;
            p_data = src_data; p_sop = src_sop; p_eop = src_eop;
            p_empty = src_empty; p_ch = src_ch;
        end
    end

    // Downstream ready: always, random, or held low.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: src_ready = 1'b1;
            1: src_ready = ($urandom_range(0, 9) < 7);
            default: src_ready = 1'b0;
        endcase
    end

    task automatic send_beat(input logic [63:0] d, input logic s, input logic e,
                             input logic [2:0] em, input logic [9:0] c);
        int n = 0;
        snk_data = d; snk_sop = s; snk_eop = e; snk_empty = em; snk_ch = c;
        snk_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (snk_ready) break;
            if (++n > 300) begin
                chk("beat_timeout", 128'd1, 128'd0);
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        snk_valid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [9:0] c, input logic [2:0] em,
                            input int gap, input bit viol);
        logic [63:0] d;
        for (int i = 0; i < len; i++) begin
            d = {$urandom, $urandom};
            sent.push_back(d);
            send_beat(d, i == 0, i == len - 1, em,
                      (viol && i == 1) ? c + 10'd1 : c);
            repeat ($urandom_range(0, gap)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_words(input int n);
        int t = 0;
        while (log_q.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("wait_words", 128'(log_q.size() >= n), 128'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_q.delete();
        hs_cyc.delete();
        sent.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        snk_data = '0; snk_sop = 0; snk_eop = 0; snk_empty = '0; snk_ch = '0;
        snk_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {src_data, src_sop, src_eop, src_empty, src_ch, src_valid},
            '0);
        chk("rst_err", 128'(src_err), 128'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 128'(snk_ready), 128'd1);
        @(posedge clk);
        #1;

        // three-beat packet, empty_in 2, channel 5
        clear_logs();
        send_pkt(3, 10'd5, 3'd2, 0, 0);
        wait_words(2);
        if (log_q.size() >= 2) begin
            chk("t1_w0_data", log_q[0].data, {sent[0], sent[1]});
            chk("t1_w0_ctl", {log_q[0].sop, log_q[0].eop, log_q[0].empty, log_q[0].ch},
                {1'b1, 1'b0, 4'd0, 10'd5});
            chk("t1_w1_data", log_q[1].data, {sent[2], 64'd0});
            chk("t1_w1_ctl", {log_q[1].sop, log_q[1].eop, log_q[1].empty, log_q[1].ch},
                {1'b0, 1'b1, 4'd10, 10'd5});
        end

        // single-beat packet
        clear_logs();
        send_pkt(1, 10'd9, 3'd0, 0, 0);
        wait_words(1);
        if (log_q.size() >= 1) begin
            chk("t2_data", log_q[0].data, {sent[0], 64'd0});
            chk("t2_ctl", {log_q[0].sop, log_q[0].eop, log_q[0].empty},
                {1'b1, 1'b1, 4'd8});
        end

        // backpressure for 5 cycles
        clear_logs();
        rdy_mode = 2;
        send_pkt(2, 10'd7, 3'd1, 0, 0);
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold", {src_valid, snk_ready}, {1'b1, 1'b0});
        end
        rdy_mode = 0;
        wait_words(1);
        if (log_q.size() >= 1)
            chk("t3_data", log_q[0].data, {sent[0], sent[1]});

        // full throughput, 10 beats back to back
        clear_logs();
        send_pkt(10, 10'd2, 3'd0, 0, 0);
        wait_words(5);
        chk("t4_count", 128'(log_q.size()), 128'd5);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("t4_spacing", 128'(hs_cyc[i] - hs_cyc[i-1]), 128'd2);

        // asynchronous reset mid-packet
        repeat (3) @(posedge clk);
        #1;
        send_beat({$urandom, $urandom}, 1'b1, 1'b0, 3'd0, 10'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async", {src_data, src_sop, src_eop, src_empty, src_ch, src_valid}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        send_pkt(2, 10'd6, 3'd3, 0, 0);
        wait_words(1);
        if (log_q.size() >= 1) begin
            chk("t5_data", log_q[0].data, {sent[0], sent[1]});
            chk("t5_ctl", {log_q[0].sop, log_q[0].eop, log_q[0].empty, log_q[0].ch},
                {1'b1, 1'b1, 4'd3, 10'd6});
        end

        // channel change on beat 2
        clear_logs();
        send_pkt(3, 10'd3, 3'd0, 0, 1);
        wait_words(2);
`ifdef AVST_UPCONV_PROTOCOL_CHECK_EN
        if (log_q.size() >= 2)
            chk("t6_err", {log_q[0].err, log_q[1].err}, {1'b1, 1'b0});
`endif

        // random traffic with random backpressure
        rdy_mode = 1;
        repeat (40)
            send_pkt($urandom_range(1, 9), 10'($urandom), 3'($urandom), 2,
                     $urandom_range(0, 5) == 0);
        rdy_mode = 0;
        begin
            int t = 0;
            while (exp_q.size() > 0 && t < 500) begin
                @(negedge clk);
                t++;
            end
        end
        @(negedge clk);
        chk("drain", {96'(exp_q.size()), 32'(beats.size())}, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
